noc_channel_sender: RTL and testbench
=====================================

# noc_channel_sender

Transmit-side endpoint for one NoC channel. It buffers locally generated flits in a small FIFO and drives them onto a channel's send interface with valid/ready flit handshaking. A packet may only start when the downstream virtual channel reports ready. It is the injection counterpart of the per-channel receive ports on the NoC connector, and sits between a local engine and a router input.

## Interface
- DATA_WIDTH, 32, flit width; equals the NoC data width.
- FIFO_AW, 2, FIFO address bits; depth = 2^FIFO_AW (default 4).
- noc_clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  local flit offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_flit  in  DATA_WIDTH  local flit payload.
- in_is_header  in  1  flit is first of packet.
- in_is_tail  in  1  flit is last of packet; header+tail both 1 means a single-flit packet.
- send_valid  out  1  flit on send_flit is valid.
- send_ready  in  1  downstream accepts flit this cycle.
- send_flit  out  DATA_WIDTH  outgoing flit (FIFO head).
- send_VCready  in  1  downstream VC free; gates header launch only.
- send_is_header  out  1  header marker of outgoing flit.
- send_is_tail  out  1  tail marker of outgoing flit.
- pkt_sent_cnt  out  16  tail flits transferred; wraps at 2^16.
- drop_cnt  out  8  orphan flits discarded; saturates at 255.

## Operation
- FIFO is first-word-fall-through and stores {is_header, is_tail, flit}. Push = in_valid && in_ready. Pop = transfer or drop.
- Transfer = send_valid && send_ready.
- The FSM has two states: IDLE (between packets) and BODY (packet in flight).
- IDLE, FIFO empty: send_valid=0.
- IDLE, head is_header=1: send_valid = send_VCready.
  - Transfer with tail=1: stay IDLE and increment pkt_sent_cnt.
  - Transfer with tail=0: go to BODY.
- IDLE, head is_header=0 (orphan): send_valid=0. The head is popped in that cycle and drop_cnt increments (saturating). State stays IDLE.
- BODY: send_valid = FIFO non-empty. send_VCready is ignored.
  - Transfer with tail=1: go to IDLE and increment pkt_sent_cnt.
  - A head with is_header=1 in BODY is sent as-is; the FSM does not restart the packet. The protocol requires the source never to do this.
- send_flit, send_is_header and send_is_tail always reflect the FIFO head. They are don't-care when send_valid=0; the bench checks them only when send_valid=1.
- Push while full is not accepted (in_ready=0). A simultaneous pop does not free a slot in the same cycle.
- Push and pop in the same cycle when not full: both take effect and occupancy is unchanged.

## Timing
- Reset (asynchronous, rst_n=0):
  - FIFO empties, state=IDLE, both counters=0.
  - Outputs: in_ready=1, send_valid=0, send_is_header=0, send_is_tail=0, send_flit=0.
- Latency: a flit pushed at edge t is presented at the send interface after edge t (one cycle). With send_ready=1 and VC ready, it transfers at edge t+1.
- send_valid is combinational from FIFO state, FSM state and send_VCready. It never depends on send_ready.
- Once send_valid=1 in BODY, the flit is held stable until transferred.
- In IDLE, a header may withdraw send_valid if send_VCready drops. The downstream must sample VCready and valid in the same cycle.
- Throughput: one flit per cycle sustained when send_ready=1.
- Counters update on the edge of the qualifying transfer or drop.
- Reset asserted mid-packet: the in-flight packet is abandoned and the FIFO is cleared. After release the block waits for a new header.

## Test plan
- Single-flit packet: push header+tail flit 0xA5 with VCready=1 and send_ready=1.
  -> send_valid high one cycle after push; flit 0xA5 transferred with header=1, tail=1; pkt_sent_cnt=1.
- VC gating: push 3-flit packet (H, B, T) with VCready=0 for 5 cycles, then 1.
  -> send_valid=0 throughout the wait, then 3 consecutive transfers. Deassert VCready after the header: body and tail still send.
- Backpressure: 4-flit packet with send_ready toggling 1,0,0,1,….
  -> flits held stable while stalled, order preserved, no duplicates.
- Full FIFO: push 5 flits with send_ready=0.
  -> in_ready=0 after the 4th push and the 5th is not accepted. Release send_ready and push/pop together: occupancy holds at 3.
- Orphan drop: push body flit 0x11 (header=0) in IDLE, then a header+tail packet.
  -> 0x11 never appears on send, drop_cnt=1, packet sent normally. Saturation: 300 orphans -> drop_cnt=255.
- Reset mid-packet: assert rst_n=0 after header and one body flit.
  -> immediately send_valid=0, counters 0, in_ready=1. A new packet after release sends correctly.

Source files
------------

// File: rtl/noc_channel_sender_if.sv
// Local injection and NoC send-side handshake bundle for one channel.
// master: the sender endpoint; slave: the local engine plus the router input.
interface noc_channel_sender_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_flit;
    logic                  in_is_header;
    logic                  in_is_tail;
    logic                  send_valid;
    logic                  send_ready;
    logic [DATA_WIDTH-1:0] send_flit;
    logic                  send_VCready;
    logic                  send_is_header;
    logic                  send_is_tail;

    modport master (
        input  in_valid, in_flit, in_is_header, in_is_tail,
        output in_ready,
        output send_valid, send_flit, send_is_header, send_is_tail,
        input  send_ready, send_VCready
    );

    modport slave (
        output in_valid, in_flit, in_is_header, in_is_tail,
        input  in_ready,
        input  send_valid, send_flit, send_is_header, send_is_tail,
        output send_ready, send_VCready
    );
endinterface

// File: rtl/noc_channel_sender.sv
// NoC channel injection endpoint: FWFT flit FIFO feeding a send port,
// header launch gated by downstream VC ready, orphan flits discarded.
module noc_channel_sender #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_AW    = 2
) (
    input  logic                 noc_clk,
    input  logic                 rst_n,
    noc_channel_sender_if.master bus,
    output logic [15:0]          pkt_sent_cnt,
    output logic [7:0]           drop_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef struct packed {
        logic                  hdr;
        logic                  tail;
        logic [DATA_WIDTH-1:0] flit;
    } entry_t;

    typedef enum logic {
        IDLE,
        BODY
    } state_t;

    entry_t       mem [DEPTH];
    entry_t       head;
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic         empty;
    logic         full;
    logic         push;
    logic         pop;
    logic         xfer;
    logic         drop;
    logic         send_valid;
    state_t       state;
    state_t       state_d;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign head  = mem[rd_ptr[FIFO_AW-1:0]];

    assign push  = bus.in_valid && !full;
    assign xfer  = send_valid && bus.send_ready;
    assign pop   = xfer || drop;

    assign bus.in_ready       = !full;
    assign bus.send_valid     = send_valid;
    // Head fields are forced to zero when empty so reset presents zeros.
    assign bus.send_flit      = empty ? '0 : head.flit;
    assign bus.send_is_header = !empty && head.hdr;
    assign bus.send_is_tail   = !empty && head.tail;

    always_ff @(posedge noc_clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= '{
                hdr:  bus.in_is_header,
                tail: bus.in_is_tail,
                flit: bus.in_flit
            };
        end
    end

    always_ff @(posedge noc_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge noc_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // VC ready only matters for launching a header from IDLE.
    always_comb begin
        send_valid = 1'b0;
        drop       = 1'b0;
        state_d    = state;
        if (!empty) begin
            unique case (state)
                IDLE: begin
                    if (head.hdr) begin
                        send_valid = bus.send_VCready;
                        if (bus.send_VCready && bus.send_ready &&
                            !head.tail)
                            state_d = BODY;
                    end else begin
                        drop = 1'b1;
                    end
                end
                BODY: begin
                    send_valid = 1'b1;
                    if (bus.send_ready && head.tail)
                        state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge noc_clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_sent_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            if (xfer && head.tail)
                pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_noc_channel_sender.sv
// Scoreboard bench for noc_channel_sender: directed packets pushed in,
// a negedge monitor pops expected flits on every send transfer.
module tb_noc_channel_sender;
    logic        noc_clk;
    logic        rst_n;
    logic [15:0] pkt_sent_cnt;
    logic [7:0]  drop_cnt;

    noc_channel_sender_if #(.DATA_WIDTH(32)) bus ();

    noc_channel_sender #(
        .DATA_WIDTH(32),
        .FIFO_AW(2)
    ) dut (
        .noc_clk      (noc_clk),
        .rst_n        (rst_n),
        .bus          (bus.master),
        .pkt_sent_cnt (pkt_sent_cnt),
        .drop_cnt     (drop_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] sb [$];
    bit          stall_prev;
    logic [33:0] stall_val;

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge noc_clk);
            #1;
        end
    endtask

    task automatic push(input logic h, input logic t,
                        input logic [31:0] f, input bit exp);
        bit ok;
        ok = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_is_header = h;
        bus.in_is_tail   = t;
        bus.in_flit      = f;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge noc_clk);
            ok = bus.in_ready;
            @(posedge noc_clk);
            #1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: flit 0x%0h never accepted", f);
        end else if (exp) begin
            sb.push_back({h, t, f});
        end
        bus.in_valid = 1'b0;
    endtask

    always @(negedge noc_clk) begin
        if (rst_n) begin
            if (stall_prev)
                chk("held_stable",
                    64'({bus.send_valid, bus.send_is_header,
                         bus.send_is_tail, bus.send_flit}),
                    64'({1'b1, stall_val}));
            if (bus.send_valid && bus.send_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_xfer", 64'(bus.send_flit), 64'hDEAD);
                end else begin
                    chk("xfer_flit",
                        64'({bus.send_is_header, bus.send_is_tail,
                             bus.send_flit}),
                        64'(sb.pop_front()));
                end
            end
            stall_prev = bus.send_valid && !bus.send_ready;
            stall_val  = {bus.send_is_header, bus.send_is_tail,
                          bus.send_flit};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        stall_prev       = 1'b0;
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_is_header = 1'b0;
        bus.in_is_tail   = 1'b0;
        bus.in_flit      = '0;
        bus.send_ready   = 1'b1;
        bus.send_VCready = 1'b1;
        #2;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_send_valid", 64'(bus.send_valid), 64'd0);
        chk("rst_markers_flit",
            64'({bus.send_is_header, bus.send_is_tail, bus.send_flit}),
            64'd0);
        chk("rst_counters", 64'({pkt_sent_cnt, drop_cnt}), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        push(1'b1, 1'b1, 32'hA5, 1'b1);
        chk("lat_valid", 64'(bus.send_valid), 64'd1);
        tick(1);
        chk("single_pkt_cnt", 64'(pkt_sent_cnt), 64'd1);
        chk("single_idle", 64'(bus.send_valid), 64'd0);

        bus.send_VCready = 1'b0;
        push(1'b1, 1'b0, 32'h100, 1'b1);
        push(1'b0, 1'b0, 32'h101, 1'b1);
        push(1'b0, 1'b1, 32'h102, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("vc_gate_wait", 64'(bus.send_valid), 64'd0);
            tick(1);
        end
        bus.send_VCready = 1'b1;
        tick(1);
        bus.send_VCready = 1'b0;
        tick(2);
        chk("vc_gate_pkt_cnt", 64'(pkt_sent_cnt), 64'd2);
        chk("vc_gate_drained", 64'(bus.send_valid), 64'd0);
        bus.send_VCready = 1'b1;

        bus.send_ready = 1'b0;
        push(1'b1, 1'b0, 32'h200, 1'b1);
        push(1'b0, 1'b0, 32'h201, 1'b1);
        push(1'b0, 1'b0, 32'h202, 1'b1);
        push(1'b0, 1'b1, 32'h203, 1'b1);
        for (int i = 0; i < 20 && pkt_sent_cnt != 16'd3; i++) begin
            bus.send_ready = pat[i % 4];
            tick(1);
        end
        chk("bp_pkt_cnt", 64'(pkt_sent_cnt), 64'd3);

        bus.send_ready = 1'b0;
        push(1'b1, 1'b0, 32'h300, 1'b1);
        push(1'b0, 1'b0, 32'h301, 1'b1);
        push(1'b0, 1'b0, 32'h302, 1'b1);
        push(1'b0, 1'b1, 32'h303, 1'b1);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid     = 1'b1;
        bus.in_is_header = 1'b1;
        bus.in_is_tail   = 1'b0;
        bus.in_flit      = 32'h310;
        tick(2);
        chk("full_reject", 64'(bus.in_ready), 64'd0);
        chk("full_head", 64'(bus.send_flit), 64'h300);
        bus.send_ready = 1'b1;
        push(1'b1, 1'b0, 32'h310, 1'b1);
        chk("occ3_ready_a", 64'(bus.in_ready), 64'd1);
        push(1'b0, 1'b0, 32'h311, 1'b1);
        push(1'b0, 1'b0, 32'h312, 1'b1);
        chk("occ3_ready_b", 64'(bus.in_ready), 64'd1);
        push(1'b0, 1'b1, 32'h313, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("occ3_drain", 64'(bus.send_valid), 64'd1);
            tick(1);
        end
        chk("occ3_empty", 64'(bus.send_valid), 64'd0);
        chk("full_pkt_cnt", 64'(pkt_sent_cnt), 64'd5);

        push(1'b0, 1'b0, 32'h11, 1'b0);
        push(1'b1, 1'b1, 32'h22, 1'b1);
        chk("orphan_drop_cnt", 64'(drop_cnt), 64'd1);
        tick(1);
        chk("orphan_pkt_cnt", 64'(pkt_sent_cnt), 64'd6);
        for (int i = 0; i < 254; i++)
            push(1'b0, 1'b0, 32'h1000 + 32'(i), 1'b0);
        tick(1);
        chk("drop_reach_255", 64'(drop_cnt), 64'd255);
        for (int i = 0; i < 45; i++)
            push(1'b0, 1'b0, 32'h2000 + 32'(i), 1'b0);
        tick(1);
        chk("drop_saturate", 64'(drop_cnt), 64'd255);

        push(1'b1, 1'b0, 32'h400, 1'b1);
        push(1'b0, 1'b0, 32'h401, 1'b1);
        bus.send_ready = 1'b0;
        tick(1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 64'(bus.send_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_counters", 64'({pkt_sent_cnt, drop_cnt}), 64'd0);
        tick(1);
        rst_n = 1'b1;
        bus.send_ready = 1'b1;
        tick(1);
        push(1'b0, 1'b0, 32'h4FF, 1'b0);
        push(1'b1, 1'b0, 32'h500, 1'b1);
        push(1'b0, 1'b1, 32'h501, 1'b1);
        tick(2);
        chk("post_rst_pkt_cnt", 64'(pkt_sent_cnt), 64'd1);
        chk("post_rst_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
